// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel switch debouncer.
// Each channel has its own synchroniser, stable-interval counter, registered level
// and one-cycle rise/fall pulses. A shared prescaler spaces out the debounce ticks.
module multi_debouncer #(
  parameter int unsigned          N_CH        = 4,
  parameter int unsigned          TICKS       = 16,
  parameter int unsigned          PRESCALE    = 62500,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [N_CH-1:0]      INIT        = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] i_switch,
  output logic [N_CH-1:0] o_switch,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic            o_any_change
);

  localparam int unsigned CW = (TICKS + 1 > 1) ? $clog2(TICKS + 1) : 1;

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] sync;
  logic            tick;

  logic [CW-1:0]   cnt   [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] sw_d;
  logic [N_CH-1:0] rise_d;
  logic [N_CH-1:0] fall_d;

  // Synchroniser chain; stage 0 samples the raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= INIT;
    end else begin
      sync_q[0] <= i_switch;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam int unsigned PW = $clog2(PRESCALE);
      logic [PW-1:0] pre_cnt;

      // Free-running prescaler 0..PRESCALE-1; tick on the terminal count.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + PW'(1);
      end

      assign tick = (pre_cnt == PW'(PRESCALE - 1));
    end
  endgenerate

  // Per-channel next state: a match restarts the window; a full window of
  // mismatching ticks accepts the new level and raises the matching pulse.
  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      cnt_d[k]  = cnt[k];
      sw_d[k]   = o_switch[k];
      rise_d[k] = 1'b0;
      fall_d[k] = 1'b0;
      if (sync[k] == o_switch[k]) begin
        cnt_d[k] = '0;
      end else if (tick) begin
        if (cnt[k] == CW'(TICKS - 1)) begin
          cnt_d[k]  = '0;
          sw_d[k]   = sync[k];
          rise_d[k] = sync[k];
          fall_d[k] = ~sync[k];
        end else begin
          cnt_d[k] = cnt[k] + CW'(1);
        end
      end
    end
  end

  // Register counters, levels and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_CH; k++) cnt[k] <= '0;
      o_switch     <= INIT;
      o_rise       <= '0;
      o_fall       <= '0;
      o_any_change <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) cnt[k] <= cnt_d[k];
      o_switch     <= sw_d;
      o_rise       <= rise_d;
      o_fall       <= fall_d;
      o_any_change <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: one instance with PRESCALE=1, one with PRESCALE=5.
module tb_multi_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic [3:0] o_switch, o_rise, o_fall;
  logic       o_any;
  logic [3:0] sw_p = 4'b0000;
  logic [3:0] o_switch_p, o_rise_p, o_fall_p;
  logic       o_any_p;

  int vectors = 0;
  int miscompares = 0;
  int any_seen = 0;
  int base;
  int n;
  logic in_range;

  always #5 clk = ~clk;

  multi_debouncer #(.N_CH(4), .TICKS(4), .PRESCALE(1), .SYNC_STAGES(2), .INIT(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .i_switch(sw),
    .o_switch(o_switch), .o_rise(o_rise), .o_fall(o_fall), .o_any_change(o_any)
  );

  multi_debouncer #(.N_CH(4), .TICKS(4), .PRESCALE(5), .SYNC_STAGES(2), .INIT(4'b0000)) dut_p (
    .clk(clk), .rst_n(rst_n), .i_switch(sw_p),
    .o_switch(o_switch_p), .o_rise(o_rise_p), .o_fall(o_fall_p), .o_any_change(o_any_p)
  );

  // Count every cycle in which the main instance reports a change.
  always @(negedge clk) if (o_any === 1'b1) any_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    sw = v;
  endtask

  initial begin
    // Reset with all inputs high
    sw = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sw",   o_switch, 4'b0000);
    chk("rst_rise", o_rise,   4'b0000);
    chk("rst_fall", o_fall,   4'b0000);
    chk("rst_any",  o_any,    1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    chk("rel_e5_sw",  o_switch, 4'b0000);
    chk("rel_e5_any", o_any,    1'b0);
    step(1);
    chk("rel_e6_sw",   o_switch, 4'b1111);
    chk("rel_e6_rise", o_rise,   4'b1111);
    chk("rel_e6_any",  o_any,    1'b1);
    step(1);
    chk("rel_e7_rise", o_rise,   4'b0000);
    chk("rel_e7_any",  o_any,    1'b0);

    // All channels back to 0
    drive(4'b0000);
    step(6);
    chk("all_fall", o_fall,   4'b1111);
    chk("all_sw0",  o_switch, 4'b0000);
    step(1);
    chk("all_fall_end", o_fall, 4'b0000);

    // Clean edge on channel 0
    drive(4'b0001);
    step(5);
    chk("c0_e5_sw", o_switch, 4'b0000);
    step(1);
    chk("c0_e6_sw",   o_switch, 4'b0001);
    chk("c0_e6_rise", o_rise,   4'b0001);
    chk("c0_e6_fall", o_fall,   4'b0000);
    step(1);
    chk("c0_e7_rise", o_rise, 4'b0000);
    drive(4'b0000);
    step(5);
    chk("c0f_e5_sw", o_switch, 4'b0001);
    step(1);
    chk("c0f_e6_sw",   o_switch, 4'b0000);
    chk("c0f_e6_fall", o_fall,   4'b0001);
    chk("c0f_e6_rise", o_rise,   4'b0000);
    step(1);
    chk("c0f_e7_fall", o_fall, 4'b0000);

    // Bounce on channel 1: 1,0,1,0 for 3 cycles each, then hold 1
    base = any_seen;
    drive(4'b0010); step(3);
    drive(4'b0000); step(3);
    drive(4'b0010); step(3);
    drive(4'b0000); step(3);
    chk("bnc_sw",   o_switch, 4'b0000);
    chk("bnc_none", any_seen, base);
    drive(4'b0010);
    step(5);
    chk("bnc_e5_sw", o_switch, 4'b0000);
    step(1);
    chk("bnc_e6_sw",   o_switch, 4'b0010);
    chk("bnc_e6_rise", o_rise,   4'b0010);
    step(1);
    chk("bnc_one_pulse", any_seen, base + 1);
    drive(4'b0000);
    step(7);
    chk("bnc_back0", o_switch, 4'b0000);

    // Glitch on channel 2 for 3 cycles
    base = any_seen;
    drive(4'b0100); step(3);
    drive(4'b0000); step(10);
    chk("gl_sw",   o_switch, 4'b0000);
    chk("gl_none", any_seen, base);

    // Channels 0 and 3 together
    base = any_seen;
    drive(4'b1001);
    step(6);
    chk("sim_sw",   o_switch, 4'b1001);
    chk("sim_rise", o_rise,   4'b1001);
    chk("sim_any",  o_any,    1'b1);
    step(1);
    chk("sim_any_end", o_any,    1'b0);
    chk("sim_count",   any_seen, base + 1);

    // Reset while channels 1 and 2 are at count 2
    drive(4'b1111);
    step(4);
    chk("mid_pre_sw", o_switch, 4'b1001);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sw",  o_switch, 4'b0000);
    chk("mid_rst_any", o_any,    1'b0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    chk("mid_e5_sw", o_switch, 4'b0000);
    step(1);
    chk("mid_e6_sw",   o_switch, 4'b1111);
    chk("mid_e6_rise", o_rise,   4'b1111);

    // Prescaled instance: stable rise on channel 3
    @(negedge clk);
    sw_p = 4'b1000;
    n = 0;
    while (n < 40 && o_switch_p[3] !== 1'b1) begin
      step(1);
      n++;
    end
    in_range = (n >= 18 && n <= 22);
    chk("ps_rise_lat_ok", in_range, 1'b1);
    chk("ps_rise_pulse",  o_rise_p, 4'b1000);

    // Prescaled fall with a one-cycle drop mid-window that must restart qualification
    @(negedge clk);
    sw_p = 4'b0000;
    step(8);
    chk("ps_mid_sw", o_switch_p, 4'b1000);
    @(negedge clk);
    sw_p = 4'b1000;
    @(negedge clk);
    sw_p = 4'b0000;
    n = 0;
    while (n < 40 && o_switch_p[3] !== 1'b0) begin
      step(1);
      n++;
    end
    in_range = (n >= 18 && n <= 22);
    chk("ps_fall_lat_ok", in_range, 1'b1);
    chk("ps_fall_pulse",  o_fall_p, 4'b1000);
    chk("ps_fall_norise", o_rise_p, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised N-channel switch/button debouncer; successor to the single-channel debouncer.
- Per channel: metastability synchroniser, stable-interval counter, registered level output, and single-cycle rise/fall event pulses.
- A shared prescaler stretches the debounce window without widening the per-channel counters.
- Sits between raw board inputs (buttons, DIP switches) and control FSMs.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- TICKS, 16, consecutive qualifying ticks of mismatch required to accept a new level (>=1).
- PRESCALE, 62500, clk cycles per debounce tick (>=1; 1 = every cycle).
- SYNC_STAGES, 2, synchroniser flop depth (>=2).
- INIT, '0 (N_CH bits), reset level of every synchroniser stage and output per channel.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; release is synchronous to clk externally.
- i_switch  input  N_CH  raw asynchronous switch levels.
- o_switch  output  N_CH  debounced levels.
- o_rise  output  N_CH  one-cycle pulse when o_switch[k] goes 0->1.
- o_fall  output  N_CH  one-cycle pulse when o_switch[k] goes 1->0.
- o_any_change  output  1  OR of all o_rise and o_fall bits, registered in the same cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All synchroniser stages and o_switch = INIT.
  - Counters = 0; prescaler = 0; o_rise = o_fall = o_any_change = 0.
  - No pulses are issued after reset release unless a real transition is qualified.
- Synchroniser: SYNC_STAGES flops per channel; sync[k] is the last stage. Only sync[k] feeds the debounce logic.
- Prescaler:
  - Shared free-running counter 0..PRESCALE-1; tick=1 in the cycle the counter equals PRESCALE-1, then it wraps to 0.
  - PRESCALE=1: tick is constant 1 and no counter is implemented.
- Per-channel counter cnt[k], width $clog2(TICKS+1), evaluated each clk edge with priority:
  1. sync[k]==o_switch[k]: cnt<=0, on any cycle regardless of tick, so a bounce restarts the window.
  2. Mismatch and tick and cnt==TICKS-1: o_switch[k]<=sync[k]; cnt<=0; pulse o_rise[k] or o_fall[k] according to the new value.
  3. Mismatch and tick: cnt<=cnt+1.
  4. Mismatch and no tick: hold.
- Latency (PRESCALE=1): input changes before edge 1 and stays stable → o_switch changes at edge SYNC_STAGES+TICKS. With PRESCALE>1, latency lies between SYNC_STAGES+(TICKS-1)*PRESCALE+1 and SYNC_STAGES+TICKS*PRESCALE cycles.
- Pulses: o_rise, o_fall and o_any_change are registered in the same cycle o_switch updates, high for exactly one clk cycle, never simultaneously rise and fall on one channel.
- Channels are independent. Simultaneous qualification on several channels sets multiple pulse bits in the same cycle; o_any_change stays a single one-cycle pulse.
- Glitch shorter than TICKS ticks: no output change, no pulse.
- Reset mid-count: counter, prescaler and output return to reset values immediately; the window restarts after release.
- Counter never exceeds TICKS-1, so there is no wrap-around.
- Input held at a new level forever: exactly one pulse, then idle.

Test Plan:
- Reset check (N_CH=4, TICKS=4, PRESCALE=1, SYNC_STAGES=2, INIT=4'b0000): hold rst_n=0 with i_switch=4'b1111 → o_switch=0 and all pulses 0 throughout reset. Release → o_switch=4'b1111 exactly at edge 6 after release (2+4); o_rise=4'b1111 and o_any_change=1 for that single cycle.
- Clean edge: i_switch[0] 0->1 before edge 1 → o_switch[0]=1 at edge 6, o_rise[0]=1 for one cycle only. Later 1->0 → o_fall[0] pulse, o_switch[0]=0 six edges after the change.
- Bounce: i_switch[1] toggles 1,0,1,0 for 3 cycles each (each shorter than 4 ticks), then holds 1 → no pulse during bouncing; o_switch[1]=1 six edges after the final edge.
- Glitch reject: a 3-cycle high pulse on i_switch[2] → o_switch[2] stays 0, no o_rise[2] or o_any_change.
- Prescale (PRESCALE=5, TICKS=4): stable change on channel 3 → o_switch[3] updates within 18..22 cycles. A 1-cycle mismatch drop mid-window clears cnt; full re-qualification is required.
- Simultaneous and reset-mid-op:
  - Channels 0 and 3 change in the same cycle → o_rise=4'b1001 in one cycle, o_any_change high one cycle.
  - Assert rst_n low at count 2 → o_switch returns to INIT immediately and the new level is accepted only after a full window post-release.
